// File: rtl/a2d_intf_if.sv
// Bundle of the motion-control request/complete handshake and the converter SPI pins.
// The slave modport is the A2D interface block; master is the requester plus converter.
interface a2d_intf_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport slave (
    input  strt_cnv, chnnl, MISO,
    output cnv_cmplt, res, SS_n, SCLK, MOSI
  );

  modport master (
    output strt_cnv, chnnl, MISO,
    input  cnv_cmplt, res, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/a2d_intf.sv
// SPI master running one 16-bit frame per accepted strt_cnv to an ADC128S-style converter.
// The returned result belongs to the channel addressed by the previous frame.
module a2d_intf #(
  parameter int SCLK_DIV_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  a2d_intf_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, BACK_PORCH} state_t;

  // Divider start value puts the first SCLK fall 10 clocks after SS_n drops.
  localparam logic [SCLK_DIV_W-1:0] DIV_START  = SCLK_DIV_W'(2**SCLK_DIV_W - 10);
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE   = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL   = {SCLK_DIV_W{1'b1}};
  localparam logic [SCLK_DIV_W-1:0] DIV_BP_END = {{(SCLK_DIV_W-1){1'b1}}, 1'b0};

  state_t                  state_q;
  logic [SCLK_DIV_W-1:0]   div_q;
  logic [SCLK_DIV_W-1:0]   div_d;
  logic [4:0]              bitcnt_q;
  logic [15:0]             tx_q;
  logic [11:0]             rx_q;
  logic                    ss_n_q;
  logic                    cmplt_q;
  logic [11:0]             res_q;

  assign div_d = div_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bitcnt_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      ss_n_q   <= 1'b1;
      cmplt_q  <= 1'b0;
      res_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.strt_cnv) begin
            tx_q     <= {2'b00, bus.chnnl, 11'h000};
            div_q    <= DIV_START;
            bitcnt_q <= '0;
            ss_n_q   <= 1'b0;
            cmplt_q  <= 1'b0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          div_q <= div_d;
          // Only the low 12 received bits are kept; the upper four shift out and are dropped.
          if (div_q == DIV_RISE) begin
            rx_q     <= {rx_q[10:0], bus.MISO};
            bitcnt_q <= bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd15) state_q <= BACK_PORCH;
          end
          // The first fall precedes any rise; bit 15 is already on MOSI then.
          if (div_q == DIV_FALL && bitcnt_q != 5'd0) begin
            tx_q <= {tx_q[14:0], 1'b0};
          end
        end
        BACK_PORCH: begin
          div_q <= div_d;
          if (div_q == DIV_BP_END) begin
            ss_n_q  <= 1'b1;
            res_q   <= rx_q;
            cmplt_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.SS_n      = ss_n_q;
  assign bus.SCLK      = (state_q == IDLE) ? 1'b1 : div_q[SCLK_DIV_W-1];
  assign bus.MOSI      = tx_q[15];
  assign bus.cnv_cmplt = cmplt_q;
  assign bus.res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: converter slave model, SCLK/MOSI capture, and a scoreboard of
// expected frames popped whenever cnv_cmplt rises.
module tb_a2d_intf;

  logic clk = 1'b0;
  logic rst;

  a2d_intf_if bus();

  a2d_intf #(.SCLK_DIV_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [11:0] res;
    logic [15:0] mosi;
    int          start;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Converter model and pin observers
  logic [15:0] slave_word = 16'h0000;
  logic        miso_force = 1'b1;
  int          total_rises = 0;
  int          total_falls = 0;
  int          rise_base = 0;
  int          fall_base = 0;
  int          frames = 0;
  int          first_fall = 0;
  int          last_rise = 0;
  int          miso_idx;
  logic [15:0] mosi_cap = 16'h0000;

  always @(negedge bus.SS_n) begin
    frames++;
    rise_base = total_rises;
    fall_base = total_falls;
  end

  always @(posedge bus.SCLK) begin
    total_rises++;
    if (bus.SS_n === 1'b0) begin
      mosi_cap  = {mosi_cap[14:0], bus.MOSI};
      last_rise = cyc;
    end
  end

  always @(negedge bus.SCLK) begin
    total_falls++;
    if (total_falls - fall_base == 1) first_fall = cyc;
  end

  always_comb begin
    miso_idx = total_rises - rise_base;
    if (miso_force) bus.MISO = 1'b1;
    else if (miso_idx >= 0 && miso_idx < 16) bus.MISO = slave_word[4'(15 - miso_idx)];
    else bus.MISO = 1'b0;
  end

  // Monitor: each rising cnv_cmplt retires the oldest expected frame
  logic cmplt_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.cnv_cmplt === 1'b1 && cmplt_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_cmplt", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("res", {20'd0, bus.res}, {20'd0, mon_e.res});
        chk("mosi_word", {16'd0, mosi_cap}, {16'd0, mon_e.mosi});
        chk("sclk_rises", total_rises - rise_base, 32'd16);
        chk("cmplt_cycle", cyc - mon_e.start, 32'd522);
        chk("first_fall_cycle", first_fall - mon_e.start, 32'd11);
        chk("last_rise_cycle", last_rise - mon_e.start, 32'd507);
        chk("ss_n_at_cmplt", {31'd0, bus.SS_n}, 32'd1);
      end
    end
    cmplt_prev = bus.cnv_cmplt;
  end

  int start_cyc;

  // Called at a negedge; strt_cnv is high for exactly one clock.
  task automatic start(input logic [2:0] ch, input logic [15:0] word, input bit push);
    slave_word   = word;
    bus.chnnl    = ch;
    bus.strt_cnv = 1'b1;
    start_cyc    = cyc;
    if (push) sb.push_back('{word[11:0], {2'b00, ch, 11'h000}, cyc});
    @(negedge clk);
    bus.strt_cnv = 1'b0;
  endtask

  task automatic wait_cmplt();
    int n;
    n = 0;
    while (bus.cnv_cmplt !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    if (n >= 700) chk("cmplt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_until(input int rel);
    while (cyc - start_cyc < rel) @(negedge clk);
  endtask

  int edges0;
  int frames0;

  initial begin
    bus.strt_cnv = 1'b0;
    bus.chnnl    = 3'd0;
    rst          = 1'b1;

    // Held in reset with MISO high: outputs idle, no SCLK activity
    repeat (2) @(negedge clk);
    edges0 = total_rises + total_falls;
    repeat (1000) @(negedge clk);
    chk("rst_ss_n", {31'd0, bus.SS_n}, 32'd1);
    chk("rst_sclk", {31'd0, bus.SCLK}, 32'd1);
    chk("rst_mosi", {31'd0, bus.MOSI}, 32'd0);
    chk("rst_cmplt", {31'd0, bus.cnv_cmplt}, 32'd0);
    chk("rst_res", {20'd0, bus.res}, 32'd0);
    chk("rst_sclk_edges", total_rises + total_falls - edges0, 32'd0);
    rst = 1'b0;
    miso_force = 1'b0;
    repeat (3) @(negedge clk);

    // Basic frame, channel 5
    start(3'd5, 16'h0ABC, 1'b1);
    wait_cmplt();
    repeat (4) @(negedge clk);

    // Upper nibble of the received word discarded; res held while idle
    start(3'd4, 16'hF123, 1'b1);
    wait_cmplt();
    repeat (20) @(negedge clk);
    chk("res_hold", {20'd0, bus.res}, 32'h123);

    // strt_cnv mid-frame is ignored
    frames0 = frames;
    start(3'd2, 16'h0456, 1'b1);
    wait_until(200);
    bus.chnnl    = 3'd7;
    bus.strt_cnv = 1'b1;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    wait_cmplt();
    repeat (600) @(negedge clk);
    chk("ignored_frames", frames - frames0, 32'd1);
    chk("ignored_sb_empty", sb.size(), 32'd0);

    // Reset mid-frame aborts immediately
    start(3'd3, 16'h0FFF, 1'b0);
    wait_until(300);
    rst = 1'b1;
    #1;
    chk("abort_ss_n", {31'd0, bus.SS_n}, 32'd1);
    chk("abort_sclk", {31'd0, bus.SCLK}, 32'd1);
    chk("abort_cmplt", {31'd0, bus.cnv_cmplt}, 32'd0);
    chk("abort_res", {20'd0, bus.res}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_abort_res", {20'd0, bus.res}, 32'd0);
    start(3'd3, 16'h0789, 1'b1);
    wait_cmplt();
    repeat (4) @(negedge clk);

    // Back-to-back: new request in the completion cycle
    start(3'd1, 16'h0111, 1'b1);
    wait_cmplt();
    start(3'd0, 16'h0222, 1'b1);
    chk("b2b_cmplt_drop", {31'd0, bus.cnv_cmplt}, 32'd0);
    wait_cmplt();
    repeat (3) @(negedge clk);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
